// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit lookahead block per stage,
// operands skewed forward and completed sum groups deskewed alongside each operation.
module pipelined_cla_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned GSAFE = (GROUP >= 1) ? GROUP : 1;
    localparam int unsigned L     = (WIDTH / GSAFE >= 1) ? WIDTH / GSAFE : 1;

    if (GROUP < 1 || (WIDTH % GSAFE) != 0) begin : g_param_check
        $error("pipelined_cla_adder: WIDTH must be a non-zero multiple of GROUP, GROUP >= 1");
    end

    // Returns {group carry-out, carry into group MSB, group sum}.
    function automatic logic [GSAFE+1:0] group_add(input logic [GSAFE-1:0] a,
                                                   input logic [GSAFE-1:0] b,
                                                   input logic             ci);
        logic [GSAFE:0]   c;
        logic [GSAFE-1:0] g;
        logic [GSAFE-1:0] p;
        logic [GSAFE-1:0] s;
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        for (int i = 0; i < int'(GSAFE); i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s = p ^ c[GSAFE-1:0];
        return {c[GSAFE], c[GSAFE-1], s};
    endfunction

    logic [WIDTH-1:0] a_q  [L];
    logic [WIDTH-1:0] b_q  [L];
    logic [WIDTH-1:0] s_q  [L];
    logic             c_q  [L];
    logic             cm_q [L];
    logic             v_q  [L];

    logic [WIDTH-1:0] a_d  [L];
    logic [WIDTH-1:0] b_d  [L];
    logic [WIDTH-1:0] s_d  [L];
    logic             c_d  [L];
    logic             cm_d [L];
    logic             v_d  [L];

    logic [WIDTH-1:0] b_in;
    logic             c0;

    always_comb begin
        logic [GSAFE+1:0] grp;
        b_in = sub ? ~y : y;
        c0   = sub ? 1'b1 : cin;

        grp     = group_add(x[GSAFE-1:0], b_in[GSAFE-1:0], c0);
        a_d[0]  = x;
        b_d[0]  = b_in;
        s_d[0]  = '0;
        s_d[0][GSAFE-1:0] = grp[GSAFE-1:0];
        c_d[0]  = grp[GSAFE+1];
        cm_d[0] = grp[GSAFE];
        v_d[0]  = in_valid;

        // Stage k consumes group k of the operands carried forward from stage k-1.
        for (int k = 1; k < int'(L); k++) begin
            grp     = group_add(a_q[k-1][k*GSAFE +: GSAFE], b_q[k-1][k*GSAFE +: GSAFE],
                                c_q[k-1]);
            a_d[k]  = a_q[k-1];
            b_d[k]  = b_q[k-1];
            s_d[k]  = s_q[k-1];
            s_d[k][k*GSAFE +: GSAFE] = grp[GSAFE-1:0];
            c_d[k]  = grp[GSAFE+1];
            cm_d[k] = grp[GSAFE];
            v_d[k]  = v_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < int'(L); k++) begin
                a_q[k]  <= '0;
                b_q[k]  <= '0;
                s_q[k]  <= '0;
                c_q[k]  <= 1'b0;
                cm_q[k] <= 1'b0;
                v_q[k]  <= 1'b0;
            end
        end else if (en) begin
            for (int k = 0; k < int'(L); k++) begin
                a_q[k]  <= a_d[k];
                b_q[k]  <= b_d[k];
                s_q[k]  <= s_d[k];
                c_q[k]  <= c_d[k];
                cm_q[k] <= cm_d[k];
                v_q[k]  <= v_d[k];
            end
        end
    end

    assign out_valid = v_q[L-1];
    assign sum       = s_q[L-1];
    assign cout      = c_q[L-1];
    assign ovf       = c_q[L-1] ^ cm_q[L-1];

    // Operand copies in the last stage have no consumer.
    logic unused_last;
    assign unused_last = ^{a_q[L-1], b_q[L-1]};

endmodule
